// File: rtl/alu_mc_pkg.sv
// Shared types for the per-lane ALU: scheduler state encoding, opcodes and ALU FSM states.
package core_states_pkg;
  localparam logic [2:0] EXECUTE = 3'b101;
endpackage

package alu_ops_pkg;
  typedef enum logic [2:0] {
    ADD = 3'd0, SUB = 3'd1, MUL = 3'd2, DIV = 3'd3,
    MOD = 3'd4, AND = 3'd5, OR  = 3'd6, XOR = 3'd7
  } alu_op_t;

  function automatic logic is_multicycle(input alu_op_t op, input logic mul_iter);
    return (op == DIV) || (op == MOD) || ((op == MUL) && mul_iter);
  endfunction
endpackage

package alu_state_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_DIV, BUSY_MUL, DONE} alu_state_t;
endpackage

// File: rtl/alu_mc_divider.sv
// Restoring radix-2 unsigned divider, one quotient bit per enabled cycle.
// quotient/remainder are valid in the cycle done is high (final step, combinational).
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [WIDTH:0]   shifted, trial;
  logic             dvs_zero;

  assign dvs_zero = (dvs_q == '0);

  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    done    = 1'b0;
    if (en) begin
      if (start) begin
        rem_d = '0;
        quo_d = dividend;
        dvs_d = divisor;
        cnt_d = CW'(WIDTH-1);
        run_d = 1'b1;
      end else if (run_q) begin
        // A zero divisor keeps the dividend parked in quo_q for the MOD result.
        if (!dvs_zero) begin
          rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          done  = 1'b1;
          run_d = 1'b0;
          cnt_d = '0;
        end
      end
    end
  end

  assign quotient  = dvs_zero ? '1    : quo_d;
  assign remainder = dvs_zero ? quo_q : rem_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// Per-lane ALU: single-cycle ADD/SUB/logic/compare, shared sequential DIV/MOD,
// optional shift-add MUL. Results are registered and held until the next result.
module alu_mc
  import alu_ops_pkg::*;
  import alu_state_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int MUL_ITERATIVE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       core_state,
  input  logic [2:0]       decoded_alu_op,
  input  logic             decoded_alu_output_mux,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_busy
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  alu_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d, prod_next;
  logic             is_mod_q, is_mod_d;
  logic             in_exec, multi, div_start, div_done;
  logic [WIDTH-1:0] div_quo, div_rem, single_res;
  logic [WIDTH:0]   cmp_diff;
  logic [WIDTH+2:0] cmp_vec;
  logic             lt, eq, gt;
  alu_op_t          op;

  assign op        = alu_op_t'(decoded_alu_op);
  assign in_exec   = (core_state == core_states_pkg::EXECUTE);
  assign multi     = !decoded_alu_output_mux && is_multicycle(op, MUL_ITERATIVE != 0);
  assign prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);

  // Sign-extend by one bit so rs-rt cannot overflow.
  always_comb begin
    cmp_diff = {rs[WIDTH-1], rs} - {rt[WIDTH-1], rt};
    lt       = cmp_diff[WIDTH];
    eq       = (cmp_diff == '0);
    gt       = !lt && !eq;
    cmp_vec  = {WIDTH'(0), gt, eq, lt};
    case (op)
      ADD:     single_res = rs + rt;
      SUB:     single_res = rs - rt;
      MUL:     single_res = rs * rt;
      AND:     single_res = rs & rt;
      OR:      single_res = rs | rt;
      XOR:     single_res = rs ^ rt;
      default: single_res = '0;
    endcase
    if (decoded_alu_output_mux) single_res = cmp_vec[WIDTH-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_out_d = alu_out_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    is_mod_d  = is_mod_q;
    div_start = 1'b0;
    if (enable) begin
      case (state_q)
        IDLE: if (in_exec) begin
          if (!multi) begin
            alu_out_d = single_res;
          end else begin
            cnt_d = CW'(WIDTH-1);
            if (op == MUL) begin
              state_d  = BUSY_MUL;
              mcand_d  = rs;
              mplier_d = rt;
              prod_d   = '0;
            end else begin
              state_d   = BUSY_DIV;
              div_start = 1'b1;
              is_mod_d  = (op == MOD);
            end
          end
        end
        BUSY_DIV: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            alu_out_d = is_mod_q ? div_rem : div_quo;
            cnt_d     = '0;
            state_d   = DONE;
          end
        end
        BUSY_MUL: begin
          prod_d   = prod_next;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            alu_out_d = prod_next;
            cnt_d     = '0;
            state_d   = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign alu_busy = (state_q == BUSY_DIV) || (state_q == BUSY_MUL) ||
                    ((state_q == IDLE) && enable && in_exec && multi);
  assign alu_out  = alu_out_q;

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .reset    (reset),
    .en       (enable),
    .start    (div_start),
    .dividend (rs),
    .divisor  (rt),
    .quotient (div_quo),
    .remainder(div_rem),
    .done     (div_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      alu_out_q <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      is_mod_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_out_q <= alu_out_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      prod_q    <= prod_d;
      is_mod_q  <= is_mod_d;
    end
  end

  logic unused_ok;
  assign unused_ok = div_done;
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: table of single-cycle vectors plus hand sequences for DIV/MOD,
// mid-op reset and iterative MUL with enable freeze; expected values go through a queue.
module tb_alu_mc;
  import alu_ops_pkg::*;

  localparam int W = 8;
  localparam logic [2:0] EXEC = core_states_pkg::EXECUTE;

  logic         clk = 1'b0, reset = 1'b1, enable = 1'b1, mux = 1'b0, sel = 1'b0;
  logic [2:0]   core_state = 3'd0, op = 3'd0;
  logic [W-1:0] rs = '0, rt = '0, out0, out1, out_s;
  logic         busy0, busy1, busy_s;
  int           n_cmp = 0, n_bad = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    alu_op_t      op;
    logic         mux;
    logic [W-1:0] a, b, exp;
  } vec_t;
  vec_t tbl[12];

  always #5 clk = ~clk;

  assign out_s  = sel ? out1 : out0;
  assign busy_s = sel ? busy1 : busy0;

  alu_mc #(.WIDTH(W), .MUL_ITERATIVE(0)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .decoded_alu_op(op), .decoded_alu_output_mux(mux), .rs(rs), .rt(rt),
    .alu_out(out0), .alu_busy(busy0));

  alu_mc #(.WIDTH(W), .MUL_ITERATIVE(1)) u_dut_it (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .decoded_alu_op(op), .decoded_alu_output_mux(mux), .rs(rs), .rt(rt),
    .alu_out(out1), .alu_busy(busy1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_chk(input string name, input logic [W-1:0] act);
    if (exp_q.size() == 0) chk({name, " scoreboard empty"}, 1, 0);
    else chk(name, act, exp_q.pop_front());
  endtask

  task automatic single(input logic s, input alu_op_t o, input logic m,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e, input string name);
    @(negedge clk);
    sel = s; core_state = EXEC; op = o; mux = m; rs = a; rt = b;
    exp_q.push_back(e);
    #1 chk({name, " busy"}, busy_s, 0);
    @(negedge clk);
    core_state = 3'd0;
    pop_chk(name, out_s);
  endtask

  task automatic multi(input logic s, input alu_op_t o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] e, input string name,
                       input int frz_at, input int frz_len);
    int busy_cnt = 0, cyc = 0;
    logic [W-1:0] prev;
    @(negedge clk);
    sel = s; core_state = EXEC; op = o; mux = 1'b0; rs = a; rt = b;
    prev = out_s;
    exp_q.push_back(e);
    #1;
    while (busy_s && cyc < 60) begin
      busy_cnt++;
      @(negedge clk);
      cyc++;
      if (!enable) begin
        chk({name, " frozen out"}, out_s, prev);
        chk({name, " frozen busy"}, busy_s, 1);
      end
      if (frz_len > 0 && cyc == frz_at) enable = 1'b0;
      if (frz_len > 0 && cyc == frz_at + frz_len) enable = 1'b1;
      #1;
    end
    chk({name, " busy cycles"}, busy_cnt, W + 1 + frz_len);
    core_state = 3'd0;
    pop_chk(name, out_s);
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{ADD, 1'b0, 8'd200, 8'd100, 8'd44};
    tbl[1]  = '{SUB, 1'b0, 8'd5,   8'd10,  8'd251};
    tbl[2]  = '{MUL, 1'b0, 8'd20,  8'd13,  8'd4};
    tbl[3]  = '{MUL, 1'b0, 8'd15,  8'd15,  8'd225};
    tbl[4]  = '{AND, 1'b0, 8'hCC,  8'hAA,  8'h88};
    tbl[5]  = '{OR,  1'b0, 8'hCC,  8'hAA,  8'hEE};
    tbl[6]  = '{XOR, 1'b0, 8'hCC,  8'hAA,  8'h66};
    tbl[7]  = '{ADD, 1'b1, 8'hFE,  8'h01,  8'd1};
    tbl[8]  = '{DIV, 1'b1, 8'd9,   8'd9,   8'd2};
    tbl[9]  = '{MUL, 1'b1, 8'h7F,  8'h80,  8'd4};
    tbl[10] = '{MOD, 1'b1, 8'h80,  8'h7F,  8'd1};
    tbl[11] = '{ADD, 1'b0, 8'd255, 8'd1,   8'd0};

    repeat (2) @(negedge clk);
    chk("reset out", out0, 0);
    chk("reset busy", busy0, 0);
    chk("reset out it", out1, 0);
    chk("reset busy it", busy1, 0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      single(1'b0, tbl[i].op, tbl[i].mux, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("vec%0d", i));

    repeat (10) @(negedge clk);
    multi(1'b0, DIV, 8'd100, 8'd7,  8'd14,  "div 100/7", 0, 0);
    multi(1'b0, MOD, 8'd100, 8'd7,  8'd2,   "mod 100/7", 0, 0);
    multi(1'b0, DIV, 8'd55,  8'd0,  8'hFF,  "div by 0", 0, 0);
    multi(1'b0, MOD, 8'd55,  8'd0,  8'd55,  "mod by 0", 0, 0);
    multi(1'b0, DIV, 8'd200, 8'd3,  8'd66,  "div 200/3", 0, 0);
    multi(1'b0, MOD, 8'd255, 8'd16, 8'd15,  "mod 255/16", 0, 0);

    // Reset lands after the third iteration of a DIV.
    @(negedge clk);
    sel = 1'b0; core_state = EXEC; op = DIV; mux = 1'b0; rs = 8'd100; rt = 8'd7;
    repeat (4) @(negedge clk);
    reset = 1'b1; core_state = 3'd0;
    @(negedge clk);
    reset = 1'b0;
    #1 chk("midop reset out", out0, 0);
    chk("midop reset busy", busy0, 0);
    multi(1'b0, DIV, 8'd9, 8'd2, 8'd4, "div 9/2 after reset", 0, 0);

    multi(1'b1, MUL, 8'd13,  8'd11,  8'd143, "imul 13x11", 0, 0);
    multi(1'b1, MUL, 8'd25,  8'd11,  8'd19,  "imul frozen", 2, 3);
    multi(1'b1, MUL, 8'd255, 8'd255, 8'd1,   "imul 255x255", 0, 0);
    single(1'b1, ADD, 1'b0, 8'd3, 8'd4, 8'd7, "it add");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
